// File: rtl/tile_color_pkg.sv
// Shared types and constants for the nearest-palette-entry colour encoder.
// RGB is packed {r,g,b}, four bits per channel.
package tile_color_pkg;

  localparam int PAL_DEPTH = 16;
  localparam int IDX_W     = 4;
  localparam int CH_W      = 4;
  localparam int DIST_W    = 6;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } enc_state_t;

  // Entry 1 is pure red, every other entry pure green.
  localparam rgb12_t PAL_RESET [PAL_DEPTH] = '{
    1:       rgb12_t'(12'hF00),
    default: rgb12_t'(12'h0F0)
  };

endpackage

// File: rtl/tile_color_dist.sv
// Manhattan distance between two 12-bit colours: |dr|+|dg|+|db|, max 45.
module tile_color_dist
  import tile_color_pkg::*;
(
  input  rgb12_t            i_a,
  input  rgb12_t            i_b,
  output logic [DIST_W-1:0] o_dist
);

  logic [CH_W-1:0] w_dr;
  logic [CH_W-1:0] w_dg;
  logic [CH_W-1:0] w_db;

  always_comb begin
    w_dr   = (i_a.r >= i_b.r) ? (i_a.r - i_b.r) : (i_b.r - i_a.r);
    w_dg   = (i_a.g >= i_b.g) ? (i_a.g - i_b.g) : (i_b.g - i_a.g);
    w_db   = (i_a.b >= i_b.b) ? (i_a.b - i_b.b) : (i_b.b - i_a.b);
    o_dist = DIST_W'(w_dr) + DIST_W'(w_dg) + DIST_W'(w_db);
  end

endmodule

// File: rtl/tile_color_encoder.sv
// Maps a 12-bit pixel to the index of the nearest entry of a writable
// 16-entry palette, scanning one entry per cycle.
module tile_color_encoder
  import tile_color_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 pal_we,
  input  logic [IDX_W-1:0]     pal_waddr,
  input  logic [3*CH_W-1:0]    pal_wdata,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*CH_W-1:0]    in_rgb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_index,
  output logic                 out_exact,
  output logic                 busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE, and the
  // result is held unchanged until out_ready is seen.

  enc_state_t        r_state;
  enc_state_t        w_next_state;
  rgb12_t            r_pal [PAL_DEPTH];
  rgb12_t            r_pix;
  logic [IDX_W:0]    r_cnt;
  logic [DIST_W-1:0] r_dist_q;
  logic [DIST_W-1:0] r_best_dist;
  logic [IDX_W-1:0]  r_best_idx;
  logic [IDX_W-1:0]  r_index;
  logic              r_exact;

  logic              w_accept;
  logic              w_last;
  logic              w_take;
  logic [DIST_W-1:0] w_dist;
  logic [DIST_W-1:0] w_cand_dist;
  logic [IDX_W-1:0]  w_cand_idx;
  rgb12_t            w_rd;

  tile_color_dist u_dist (
    .i_a    (r_pix),
    .i_b    (w_rd),
    .o_dist (w_dist)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = SEARCH;
      end
      SEARCH: begin
        busy = 1'b1;
        if (r_cnt == IDX_W'(0) + (IDX_W+1)'(PAL_DEPTH)) w_next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == SEARCH) && (r_cnt == (IDX_W+1)'(PAL_DEPTH));
  assign w_rd     = r_pal[r_cnt[IDX_W-1:0]];

  // The distance of entry cnt is registered and compared one cycle later,
  // so the entry being compared is cnt-1 (wrapping to 15 on the final cycle).
  assign w_take      = (r_cnt != '0) && (r_dist_q < r_best_dist);
  assign w_cand_dist = w_take ? r_dist_q : r_best_dist;
  assign w_cand_idx  = w_take ? IDX_W'(r_cnt - 1'b1) : r_best_idx;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_pix       <= '0;
      r_cnt       <= '0;
      r_dist_q    <= '0;
      r_best_dist <= '1;
      r_best_idx  <= '0;
      r_index     <= '0;
      r_exact     <= 1'b0;
    end else if (w_accept) begin
      r_pix       <= rgb12_t'(in_rgb);
      r_cnt       <= '0;
      r_best_dist <= '1;
      r_best_idx  <= '0;
    end else if (r_state == SEARCH) begin
      r_dist_q    <= w_dist;
      r_cnt       <= r_cnt + 1'b1;
      r_best_dist <= w_cand_dist;
      r_best_idx  <= w_cand_idx;
      if (w_last) begin
        r_index <= w_cand_idx;
        r_exact <= (w_cand_dist == '0);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) r_pal[i] <= PAL_RESET[i];
    end else if (pal_we) begin
      r_pal[pal_waddr] <= rgb12_t'(pal_wdata);
    end
  end

  assign out_index = r_index;
  assign out_exact = r_exact;

endmodule

// File: tb/tb_tile_color_encoder.sv
// Bench for tile_color_encoder: fixed vectors, hand-written corner cases
// and randomized pixels/palette writes against a nearest-colour model.
module tb_tile_color_encoder;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [11:0] pal_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_rgb;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic        out_exact;
  logic        busy;

  tile_color_encoder dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .pal_we    (pal_we),
    .pal_waddr (pal_waddr),
    .pal_wdata (pal_wdata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rgb    (in_rgb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_exact (out_exact),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [4:0]  exp_q[$];
  logic [11:0] mdl_pal [16];
  int          acc_cyc;

  typedef struct {
    logic [11:0] rgb;
    logic [3:0]  idx;
    logic        exact;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl_pal[i] = (i == 1) ? 12'hF00 : 12'h0F0;
  endtask

  // Nearest palette entry by sum of absolute channel differences; the first
  // (lowest) index wins a tie. Returns {index, exact}.
  function automatic logic [4:0] nearest(input logic [11:0] px, input logic [11:0] p [16]);
    int best = 1000;
    int bi = 0;
    for (int i = 0; i < 16; i++) begin
      int d = 0;
      for (int c = 0; c < 3; c++) begin
        int a = (px >> (4*c)) & 15;
        int b = (p[i] >> (4*c)) & 15;
        d += (a > b) ? (a - b) : (b - a);
      end
      if (d < best) begin
        best = d;
        bi = i;
      end
    end
    return {4'(bi), best == 0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [11:0] d);
    @(negedge Clk);
    pal_we = 1'b1; pal_waddr = a; pal_wdata = d;
    @(negedge Clk);
    pal_we = 1'b0;
    mdl_pal[a] = d;
  endtask

  // Returns at the negedge following the accepting edge.
  task automatic send_start(input logic [11:0] rgb);
    @(negedge Clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_rgb   = rgb;
    @(negedge Clk);
    in_valid = 1'b0;
    in_rgb   = 12'($urandom);
    acc_cyc  = cyc;
    chk("in_ready_low_after_accept", in_ready, 0);
    chk("busy_after_accept", busy, 1);
  endtask

  // Write that lands on the j-th rising edge after the accept (j >= 1).
  task automatic mid_write(input int j, input logic [3:0] a, input logic [11:0] d);
    repeat (j - 1) @(negedge Clk);
    pal_we = 1'b1; pal_waddr = a; pal_wdata = d;
    @(negedge Clk);
    pal_we = 1'b0;
  endtask

  task automatic wait_result();
    for (int k = 0; k < 40; k++) begin
      if (out_valid) break;
      @(negedge Clk);
    end
    chk("out_valid_seen", out_valid, 1);
    chk("latency", cyc - acc_cyc, 17);
  endtask

  task automatic get_result(input int hold);
    logic [4:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1F;
    chk("out_index", out_index, e[4:1]);
    chk("out_exact", out_exact, e[0]);
    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_index", out_index, e[4:1]);
      chk("hold_out_exact", out_exact, e[0]);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge Clk);
    out_ready = 1'b0;
    chk("out_valid_after_consume", out_valid, 0);
    chk("in_ready_after_consume", in_ready, 1);
  endtask

  task automatic run_pixel(input logic [11:0] rgb, input logic [4:0] exp, input int hold);
    send_start(rgb);
    exp_q.push_back(exp);
    wait_result();
    get_result(hold);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [11:0] snap [16];
    logic [4:0]  e;

    vecs[0] = '{12'hF00, 4'd1, 1'b1};
    vecs[1] = '{12'h000, 4'd0, 1'b0};
    vecs[2] = '{12'h0F0, 4'd0, 1'b1};
    vecs[3] = '{12'hF0F, 4'd1, 1'b0};
    vecs[4] = '{12'h0FF, 4'd0, 1'b0};
    vecs[5] = '{12'hFF0, 4'd0, 1'b0};
    vecs[6] = '{12'h800, 4'd1, 1'b0};
    vecs[7] = '{12'h080, 4'd0, 1'b0};

    Reset_n = 1'b0; pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
    in_valid = 1'b0; in_rgb = '0; out_ready = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_exact", out_exact, 0);
    chk("rst_busy", busy, 0);

    // Default-palette vectors.
    for (int v = 0; v < 8; v++) run_pixel(vecs[v].rgb, {vecs[v].idx, vecs[v].exact}, 0);

    // Tie between two identical entries resolves to the lower index.
    pal_write(4'd7, 12'h123);
    pal_write(4'd9, 12'h123);
    run_pixel(12'h124, {4'd7, 1'b0}, 0);

    // Consumer back-pressure for 10 cycles.
    run_pixel(12'hF00, {4'd1, 1'b1}, 10);

    // Write to an entry not yet scanned is seen.
    send_start(12'hABC);
    exp_q.push_back({4'd15, 1'b1});
    mid_write(2, 4'd15, 12'hABC);
    wait_result();
    get_result(0);
    mdl_pal[15] = 12'hABC;
    pal_write(4'd15, 12'h0F0);

    // Write to an entry already scanned is not seen.
    send_start(12'hABC);
    exp_q.push_back({4'd0, 1'b0});
    mid_write(2, 4'd0, 12'hABC);
    wait_result();
    get_result(0);
    mdl_pal[0] = 12'hABC;

    // Reset mid-search drops the pixel and restores the palette.
    send_start(12'h555);
    repeat (5) @(negedge Clk);
    do_reset();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    run_pixel(12'h0F0, {4'd0, 1'b1}, 0);

    // Randomized pixels, palette writes and mid-search writes.
    for (int n = 0; n < 40; n++) begin
      int          j, k;
      logic [11:0] px, wd;
      if ($urandom_range(0, 1) == 1)
        pal_write(4'($urandom_range(0, 15)), 12'($urandom));
      px = ($urandom_range(0, 3) == 0) ? mdl_pal[$urandom_range(0, 15)] : 12'($urandom);
      send_start(px);
      if ($urandom_range(0, 2) == 0) begin
        j  = $urandom_range(1, 16);
        k  = $urandom_range(0, 15);
        wd = ($urandom_range(0, 1) == 1) ? px : 12'($urandom);
        snap = mdl_pal;
        if (j <= k) snap[k] = wd;
        e = nearest(px, snap);
        exp_q.push_back(e);
        mid_write(j, 4'(k), wd);
        mdl_pal[k] = wd;
      end else begin
        exp_q.push_back(nearest(px, mdl_pal));
      end
      wait_result();
      get_result($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
